// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types and constants for the cache refill arbiter and the caches above it.
// Holds the arbiter state encoding, requester IDs and the cache line geometry.
package cache_refill_arbiter_pkg;

   localparam int ADDR_W      = 32;
   localparam int LINE_W      = 256;
   localparam int OFFSET_BITS = 5;

   // Requester IDs double as bit positions in the two-bit request vector.
   localparam logic IC = 1'b0;
   localparam logic DC = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GNT_I  = 3'd1,
      GNT_D  = 3'd2,
      RESP_I = 3'd3,
      RESP_D = 3'd4
   } arb_state_e;

endpackage

// File: rtl/cache_refill_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// and on a tie the requester that did not win last time is chosen.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);
   import cache_refill_arbiter_pkg::*;

   // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_valid = |req;
      grant_id    = last_grant;
      unique case (req)
         2'b01:   grant_id = IC;
         2'b10:   grant_id = DC;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = last_grant;
      endcase
   end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one main memory between icache refills and dcache refills/writebacks,
// running one full-line transaction per round-robin grant and pulsing done to the winner.
module cache_refill_arbiter #(
   parameter int ADDR_W      = cache_refill_arbiter_pkg::ADDR_W,
   parameter int LINE_W      = cache_refill_arbiter_pkg::LINE_W,
   parameter int OFFSET_BITS = cache_refill_arbiter_pkg::OFFSET_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [LINE_W-1:0] ic_rdata,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              dc_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              proto_err
);
   import cache_refill_arbiter_pkg::*;

   localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_BITS) - 64'd1);

   arb_state_e        state_q,      state_d;
   logic              last_grant_q, last_grant_d;
   logic [1:0]        mask_q,       mask_d;
   logic              mem_req_q,    mem_req_d;
   logic              mem_we_q,     mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
   logic [LINE_W-1:0] mem_wdata_q,  mem_wdata_d;
   logic              ic_done_q,    ic_done_d;
   logic              dc_done_q,    dc_done_d;
   logic [LINE_W-1:0] ic_rdata_q,   ic_rdata_d;
   logic [LINE_W-1:0] dc_rdata_q,   dc_rdata_d;
   logic              proto_err_q,  proto_err_d;

   logic [1:0] req_masked;
   logic       grant_valid;
   logic       grant_id;

   // The just-served requester is masked for one IDLE cycle so a late req drop is not re-granted.
   assign req_masked[IC] = ic_req & ~mask_q[IC];
   assign req_masked[DC] = dc_req & ~mask_q[DC];

   rr_pick2 u_pick (
      .req         (req_masked),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mask_d       = 2'b00;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      ic_done_d    = 1'b0;
      dc_done_d    = 1'b0;
      ic_rdata_d   = ic_rdata_q;
      dc_rdata_d   = dc_rdata_q;
      proto_err_d  = proto_err_q | (mem_ack & ~mem_req_q);

      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               last_grant_d = grant_id;
               mem_req_d    = 1'b1;
               if (grant_id == DC) begin
                  state_d     = GNT_D;
                  mem_we_d    = dc_we;
                  mem_addr_d  = dc_addr & ~OFFSET_MASK;
                  mem_wdata_d = dc_wdata;
               end else begin
                  state_d     = GNT_I;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = ic_addr & ~OFFSET_MASK;
                  mem_wdata_d = '0;
               end
            end
         end
         GNT_I: begin
            if (mem_ack) begin
               state_d    = RESP_I;
               mem_req_d  = 1'b0;
               ic_done_d  = 1'b1;
               ic_rdata_d = mem_rdata;
            end
         end
         GNT_D: begin
            if (mem_ack) begin
               state_d   = RESP_D;
               mem_req_d = 1'b0;
               dc_done_d = 1'b1;
               if (!mem_we_q) dc_rdata_d = mem_rdata;
            end
         end
         RESP_I: begin
            state_d    = IDLE;
            mask_d[IC] = 1'b1;
         end
         RESP_D: begin
            state_d    = IDLE;
            mask_d[DC] = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values of its peers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= IC;
         mask_q       <= 2'b00;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         ic_done_q    <= 1'b0;
         dc_done_q    <= 1'b0;
         ic_rdata_q   <= '0;
         dc_rdata_q   <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mask_q       <= mask_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         ic_done_q    <= ic_done_d;
         dc_done_q    <= dc_done_d;
         ic_rdata_q   <= ic_rdata_d;
         dc_rdata_q   <= dc_rdata_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign ic_rdata  = ic_rdata_q;
   assign ic_done   = ic_done_q;
   assign dc_rdata  = dc_rdata_q;
   assign dc_done   = dc_done_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != IDLE);
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: refill latency, round-robin alternation,
// writeback, late req drop, reset mid-transaction and the sticky protocol error.
module tb_cache_refill_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_req;
   logic [AW-1:0] ic_addr;
   logic [LW-1:0] ic_rdata;
   logic          ic_done;
   logic          dc_req;
   logic          dc_we;
   logic [AW-1:0] dc_addr;
   logic [LW-1:0] dc_wdata;
   logic [LW-1:0] dc_rdata;
   logic          dc_done;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_ack;
   logic          busy;
   logic          proto_err;

   int total = 0;
   int bad   = 0;

   localparam logic [LW-1:0] P1 = {8{32'h1111_C0DE}};
   localparam logic [LW-1:0] P2 = {8{32'h2222_BEEF}};
   localparam logic [LW-1:0] P3 = {8{32'h3333_F00D}};
   localparam logic [LW-1:0] P4 = {8{32'h4444_CAFE}};
   localparam logic [LW-1:0] P5 = {8{32'h5555_1234}};
   localparam logic [LW-1:0] P6 = {8{32'h6666_ABCD}};
   localparam logic [LW-1:0] PJ = {8{32'hDEAD_DEAD}};
   localparam logic [LW-1:0] WB = {32{8'hA5}};

   cache_refill_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .ic_req    (ic_req),
      .ic_addr   (ic_addr),
      .ic_rdata  (ic_rdata),
      .ic_done   (ic_done),
      .dc_req    (dc_req),
      .dc_we     (dc_we),
      .dc_addr   (dc_addr),
      .dc_wdata  (dc_wdata),
      .dc_rdata  (dc_rdata),
      .dc_done   (dc_done),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are driven and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset     = 1'b1;
      ic_req    = 1'b0;
      ic_addr   = '0;
      dc_req    = 1'b0;
      dc_we     = 1'b0;
      dc_addr   = '0;
      dc_wdata  = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      tick();
      tick();

      check("rst_mem_req",   LW'(mem_req),   '0);
      check("rst_busy",      LW'(busy),      '0);
      check("rst_ic_done",   LW'(ic_done),   '0);
      check("rst_dc_done",   LW'(dc_done),   '0);
      check("rst_ic_rdata",  ic_rdata,       '0);
      check("rst_dc_rdata",  dc_rdata,       '0);
      check("rst_mem_addr",  LW'(mem_addr),  '0);
      check("rst_proto_err", LW'(proto_err), '0);
      reset = 1'b0;

      // icache refill, N=3: done in cycle 5 after the request
      ic_req  = 1'b1;
      ic_addr = 32'h0000_104C;
      tick();
      check("t1_mem_req",  LW'(mem_req),  LW'(1));
      check("t1_mem_addr", LW'(mem_addr), LW'(32'h0000_1040));
      check("t1_mem_we",   LW'(mem_we),   '0);
      check("t1_busy",     LW'(busy),     LW'(1));
      ic_addr = 32'h0000_9999;
      tick();
      check("t1_c2_done",  LW'(ic_done),  '0);
      check("t1_c2_addr",  LW'(mem_addr), LW'(32'h0000_1040));
      tick();
      check("t1_c3_done",  LW'(ic_done),  '0);
      tick();
      check("t1_c4_req",   LW'(mem_req),  LW'(1));
      mem_ack   = 1'b1;
      mem_rdata = P1;
      tick();
      mem_ack = 1'b0;
      check("t1_c5_done",  LW'(ic_done),  LW'(1));
      check("t1_c5_rdata", ic_rdata,      P1);
      check("t1_c5_req",   LW'(mem_req),  '0);
      check("t1_c5_perr",  LW'(proto_err), '0);
      ic_req = 1'b0;
      tick();
      check("t1_c6_done",  LW'(ic_done),  '0);
      check("t1_c6_busy",  LW'(busy),     '0);
      check("t1_c6_hold",  ic_rdata,      P1);

      // Simultaneous requests after reset: D, I, D, I
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      ic_req  = 1'b1;
      ic_addr = 32'h0000_5010;
      dc_req  = 1'b1;
      dc_we   = 1'b0;
      dc_addr = 32'h0000_3008;
      tick();
      check("rr1_addr", LW'(mem_addr), LW'(32'h0000_3000));
      mem_ack   = 1'b1;
      mem_rdata = P2;
      tick();
      mem_ack = 1'b0;
      check("rr1_dc_done", LW'(dc_done),  LW'(1));
      check("rr1_ic_done", LW'(ic_done),  '0);
      check("rr1_dc_rdata", dc_rdata,     P2);
      tick();
      check("rr1_idle_busy", LW'(busy),   '0);
      tick();
      check("rr2_addr", LW'(mem_addr), LW'(32'h0000_5000));
      mem_ack   = 1'b1;
      mem_rdata = P3;
      tick();
      mem_ack = 1'b0;
      check("rr2_ic_done", LW'(ic_done),  LW'(1));
      check("rr2_ic_rdata", ic_rdata,     P3);
      check("rr2_dc_keep",  dc_rdata,     P2);
      tick();
      tick();
      check("rr3_addr", LW'(mem_addr), LW'(32'h0000_3000));
      mem_ack   = 1'b1;
      mem_rdata = P4;
      tick();
      mem_ack = 1'b0;
      check("rr3_dc_done", LW'(dc_done),  LW'(1));
      check("rr3_dc_rdata", dc_rdata,     P4);
      dc_req = 1'b0;
      tick();
      tick();
      check("rr4_addr", LW'(mem_addr), LW'(32'h0000_5000));
      mem_ack   = 1'b1;
      mem_rdata = P5;
      tick();
      mem_ack = 1'b0;
      check("rr4_ic_done", LW'(ic_done),  LW'(1));
      ic_req = 1'b0;
      tick();

      // dcache writeback, N=1
      dc_req   = 1'b1;
      dc_we    = 1'b1;
      dc_addr  = 32'h0000_2000;
      dc_wdata = WB;
      tick();
      check("wb_mem_we",    LW'(mem_we),   LW'(1));
      check("wb_mem_addr",  LW'(mem_addr), LW'(32'h0000_2000));
      check("wb_mem_wdata", mem_wdata,     WB);
      dc_wdata = '0;
      dc_we    = 1'b0;
      tick();
      check("wb_stable_wdata", mem_wdata,   WB);
      check("wb_stable_we",    LW'(mem_we), LW'(1));
      mem_ack   = 1'b1;
      mem_rdata = PJ;
      tick();
      mem_ack = 1'b0;
      check("wb_dc_done",   LW'(dc_done), LW'(1));
      check("wb_dc_rdata",  dc_rdata,     P4);
      dc_req = 1'b0;
      tick();

      // N=0 refill, req held one cycle past done
      ic_req  = 1'b1;
      ic_addr = 32'h0000_7FFF;
      tick();
      check("n0_addr", LW'(mem_addr), LW'(32'h0000_7FE0));
      mem_ack   = 1'b1;
      mem_rdata = P5;
      tick();
      mem_ack = 1'b0;
      check("n0_done",  LW'(ic_done), LW'(1));
      check("n0_rdata", ic_rdata,     P5);
      tick();
      check("n0_late_busy", LW'(busy),    '0);
      check("n0_late_done", LW'(ic_done), '0);
      ic_req = 1'b0;
      tick();
      check("n0_no_regrant_req",  LW'(mem_req), '0);
      check("n0_no_regrant_busy", LW'(busy),    '0);

      // Reset during GNT_D
      dc_req  = 1'b1;
      dc_we   = 1'b0;
      dc_addr = 32'h0000_4000;
      tick();
      check("rstmid_pre_req", LW'(mem_req), LW'(1));
      reset = 1'b1;
      #1;
      check("rstmid_req",     LW'(mem_req), '0);
      check("rstmid_busy",    LW'(busy),    '0);
      check("rstmid_dc_done", LW'(dc_done), '0);
      check("rstmid_ic_rdata", ic_rdata,    '0);
      #2;
      reset = 1'b0;
      tick();
      check("rstmid_regrant_addr", LW'(mem_addr), LW'(32'h0000_4000));
      mem_ack   = 1'b1;
      mem_rdata = P6;
      tick();
      mem_ack = 1'b0;
      check("rstmid_done",  LW'(dc_done), LW'(1));
      check("rstmid_rdata", dc_rdata,     P6);
      dc_req = 1'b0;
      tick();

      // Stray mem_ack in IDLE
      mem_ack   = 1'b1;
      mem_rdata = PJ;
      tick();
      mem_ack = 1'b0;
      check("perr_set",     LW'(proto_err), LW'(1));
      check("perr_ic_done", LW'(ic_done),   '0);
      check("perr_dc_done", LW'(dc_done),   '0);
      check("perr_busy",    LW'(busy),      '0);
      tick();
      tick();
      check("perr_sticky",  LW'(proto_err), LW'(1));
      check("perr_rdata",   dc_rdata,       P6);
      reset = 1'b1;
      tick();
      check("perr_cleared", LW'(proto_err), '0);
      reset = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
Shares the single backing main memory between the instruction cache (read-only line refills) and the data cache (line refills and dirty-line writebacks).
- Sits below InstCache/DataCache and above the main memory model.
- Accepts level-held requests from both caches and grants one at a time, round-robin.
- Runs one full-line memory transaction per grant and returns the line plus a one-cycle done pulse to the winner.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line width in bits (matches cache block width)
OFFSET_BITS, 5, log2(LINE_W/8); address bits cleared for line alignment

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
ic_req  in  1  icache refill request, held high until ic_done
ic_addr  in  ADDR_W  icache miss address
ic_rdata  out  LINE_W  refilled line for icache, valid when ic_done=1
ic_done  out  1  one-cycle completion pulse to icache
dc_req  in  1  dcache request, held high until dc_done
dc_we  in  1  1 = writeback, 0 = refill
dc_addr  in  ADDR_W  dcache line address
dc_wdata  in  LINE_W  writeback line
dc_rdata  out  LINE_W  refilled line for dcache, valid when dc_done=1
dc_done  out  1  one-cycle completion pulse to dcache
mem_req  out  1  memory transaction request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  line-aligned memory address
mem_wdata  out  LINE_W  write line
mem_rdata  in  LINE_W  read line, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
busy  out  1  high in any state other than IDLE
proto_err  out  1  sticky: mem_ack received while mem_req=0

Behaviour:
- Reset values: all outputs 0 (rdata buses 0); state IDLE; last_grant = IC, so dcache wins the first tie.
- FSM states:
  - IDLE
  - GNT_I, GNT_D: memory transaction in flight.
  - RESP_I, RESP_D: done pulse cycle.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: grant it.
- IDLE, both requesting: grant the requester that is not last_grant; update last_grant on grant.
- On grant edge:
  - Latch mem_addr = addr with low OFFSET_BITS forced to 0.
  - Latch mem_we: dc_we for dcache, 0 for icache.
  - Latch mem_wdata: dc_wdata for dcache, 0 for icache.
  - mem_req=1 from the next cycle on.
- Latched request fields stay stable until the grant completes; requester input changes are ignored during the grant.
- GNT_x with mem_ack=1 (allowed in the first cycle mem_req is high):
  - Next edge: mem_req=0 and state RESP_x.
  - x_done=1 for exactly that cycle.
  - On reads, x_rdata latches mem_rdata; on dcache writebacks, dc_rdata is unchanged.
- RESP_x → IDLE unconditionally.
  - The winner's req is masked in RESP_x and in the following IDLE cycle, so a requester that drops req one cycle late is not re-granted.
  - The other requester may be granted from that IDLE cycle.
- Latency from req sampled in IDLE to done: 2 + N cycles, where N = cycles of mem_req high before mem_ack (N≥0). Minimum is 2.
- Back-to-back alternating requests: throughput of one line per 3+N cycles.
- Requester deasserts req mid-grant: the transaction still completes and done still pulses.
- mem_ack while mem_req=0: ignored for data; proto_err set (cleared only by reset).
- Reset asserted mid-transaction: immediately returns to IDLE with mem_req=0, no done pulse; rdata registers cleared.
- x_rdata holds its value after done until the next read completion for that requester.

Decomposition:
- Shared package:
  - Arbiter state enum {IDLE, GNT_I, GNT_D, RESP_I, RESP_D}.
  - Requester ID constants IC=0, DC=1.
  - LINE_W and OFFSET_BITS, shared with the caches.
- One natural sub-module: rr_pick2, a combinational two-way round-robin picker.
  - Inputs: masked req[1:0], last_grant.
  - Outputs: grant_valid, grant_id.
- FSM, request latches and data registers stay in cache_refill_arbiter.

Test Plan:
- Reset, then ic_req=1 with ic_addr=0x0000_104C, memory acks after N=3 → mem_addr=0x0000_1040, mem_we=0, ic_done pulses on cycle 5 after req, ic_rdata = mem_rdata pattern.
- ic_req and dc_req asserted together right after reset → dcache granted first, icache granted in the IDLE cycle after RESP_D; repeating both yields strict alternation D,I,D,I.
- dc_req=1, dc_we=1, dc_addr=0x0000_2000, dc_wdata=0xA5 repeated → mem_we=1, mem_wdata=0xA5.. while mem_req is high; dc_done pulses; dc_rdata unchanged from the prior value.
- Memory with N=0 (mem_ack in the first mem_req cycle) → done exactly 2 cycles after req; ic_req held 1 cycle past done → no second grant.
- reset asserted during GNT_D with mem_req=1 → mem_req, busy and dc_done are 0 immediately (same cycle); after release, dc_req re-asserted completes normally.
- mem_ack pulsed in IDLE → proto_err=1 and stays 1, no done pulse; only reset clears it.
